// File: rtl/mem_wb_dma_pkg.sv
// Shared types and constants for the Wishbone block-copy DMA master.
package mem_wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RGAP  = 3'd2,
        ST_WRITE = 3'd3,
        ST_WGAP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam logic [3:0]  SEL_ALL   = 4'hF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts unacknowledged strobe cycles; expired is combinational on run so the owner can abort
// in the same cycle the limit is reached. No backpressure; clear has priority over run.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the waiting cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_dma.sv
// Wishbone master copying len words src->dst, one read/write pair at a time with an idle gap after each.
// Strobe held until ack (slave backpressure), bounded by TIMEOUT; start ignored while busy.
module mem_wb_dma
    import mem_wb_dma_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    output logic             wbm_we_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    state_t           state, state_nxt;
    logic [31:0]      src_q, dst_q, dat_q;
    logic [LEN_W-1:0] rem_q;
    logic             err_q;
    logic             strobe;
    logic             expired;

    assign strobe = (state == ST_READ) || (state == ST_WRITE);

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (!strobe),
        .run      (strobe && !wbm_ack_i),
        .expired  (expired)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start_i) state_nxt = (len_i == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (wbm_ack_i) state_nxt = ST_RGAP;
                      else if (expired) state_nxt = ST_DONE;
            ST_RGAP:  state_nxt = ST_WRITE;
            ST_WRITE: if (wbm_ack_i) state_nxt = ST_WGAP;
                      else if (expired) state_nxt = ST_DONE;
            ST_WGAP:  state_nxt = (rem_q == LEN_W'(1)) ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            dat_q <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: if (start_i) begin
                    err_q <= 1'b0;
                    if (len_i != '0) begin
                        src_q <= src_i & ~32'h3;
                        dst_q <= dst_i & ~32'h3;
                        rem_q <= len_i;
                    end
                end
                ST_READ: begin
                    if (wbm_ack_i) dat_q <= wbm_dat_i;
                    else if (expired) err_q <= 1'b1;
                end
                ST_WRITE: if (!wbm_ack_i && expired) err_q <= 1'b1;
                ST_WGAP: begin
                    src_q <= src_q + ADDR_STEP;
                    dst_q <= dst_q + ADDR_STEP;
                    rem_q <= rem_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Every output decodes registered state only; ack never reaches an output combinationally.
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);
    assign err_o     = err_q;
    assign wbm_cyc_o = strobe;
    assign wbm_stb_o = strobe;
    assign wbm_we_o  = (state == ST_WRITE);
    assign wbm_adr_o = (state == ST_WRITE) ? dst_q : src_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = SEL_ALL;

endmodule

// File: tb/tb_mem_wb_dma.sv
// Directed bench for mem_wb_dma against a behavioural SRAM slave (read ack 3rd cycle, write ack 2nd).
module tb_mem_wb_dma;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i  = 1'b0;
    logic [31:0] src_i    = '0;
    logic [31:0] dst_i    = '0;
    logic [7:0]  len_i    = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    int          scnt = 0;
    logic        no_ack = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    mem_wb_dma #(.LEN_W(8), .TIMEOUT(8)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start_i   (start_i),
        .src_i     (src_i),
        .dst_i     (dst_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    // Slave model: word index from adr[7:2] wraps naturally at the top of the address space.
    assign wbm_ack_i = wbm_stb_o && !no_ack && (scnt == (wbm_we_o ? 1 : 2));
    assign wbm_dat_i = mem[wbm_adr_o[7:2]];

    always @(posedge wb_clk_i) begin
        if (wb_rst_i || !wbm_stb_o || wbm_ack_i) scnt <= 0;
        else scnt <= scnt + 1;
        if (!wb_rst_i && wbm_ack_i) begin
            if (wbm_we_o) begin
                mem[wbm_adr_o[7:2]] = wbm_dat_o;
                wr_log.push_back(wbm_adr_o);
            end else begin
                rd_log.push_back(wbm_adr_o);
            end
        end
    end

    int   r_done, r_busy, r_cyc, r_maxrun, r_bad;
    logic r_err_done, r_err1, r_post_cyc, r_post_busy;

    // Start a copy at cycle 0, observe each cycle at the falling edge until done_o or a reset.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                            input int poke_cyc, input int rst_cyc);
        int run = 0;
        r_done = -1; r_busy = 0; r_cyc = 0; r_maxrun = 0; r_bad = 0;
        r_err_done = 1'b0; r_err1 = 1'bx; r_post_cyc = 1'bx; r_post_busy = 1'bx;
        @(negedge wb_clk_i);
        start_i = 1'b1; src_i = s; dst_i = d; len_i = n;
        for (int k = 1; k <= 300; k++) begin
            @(negedge wb_clk_i);
            if (k == 1) r_err1 = err_o;
            start_i = (k == poke_cyc);
            if (k == poke_cyc) begin
                src_i = 32'h20; dst_i = 32'h30; len_i = 8'd1;
            end
            if (wbm_stb_o !== wbm_cyc_o) r_bad++;
            if (busy_o) r_busy++;
            if (wbm_cyc_o) begin
                r_cyc++; run++;
                if (run > r_maxrun) r_maxrun = run;
            end else begin
                run = 0;
            end
            if (done_o) begin
                r_done = k; r_err_done = err_o;
                break;
            end
            if (k == rst_cyc) begin
                wb_rst_i = 1'b1;
                @(negedge wb_clk_i);
                r_post_cyc = wbm_cyc_o; r_post_busy = busy_o;
                wb_rst_i = 1'b0; start_i = 1'b0;
                break;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_cyc_stb_we got %b want 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h want 0", wbm_adr_o); end
        checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", wbm_dat_o); end
        checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got %h want f", wbm_sel_o); end
        wb_rst_i = 1'b0;
    endtask

    task automatic test_basic_copy();
        logic [31:0] exp_w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
        rd_log.delete(); wr_log.delete();
        run_copy(32'h0, 32'h40, 8'd4, 5, 0);
        checks++; if (r_done !== 29) begin errors++; $display("FAIL basic_done_cycle got %0d want 29", r_done); end
        checks++; if (r_err_done !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", r_err_done); end
        checks++; if (r_busy !== 29) begin errors++; $display("FAIL basic_busy_cycles got %0d want 29", r_busy); end
        checks++; if (r_maxrun !== 3) begin errors++; $display("FAIL basic_max_strobe_run got %0d want 3", r_maxrun); end
        checks++; if (r_cyc !== 20) begin errors++; $display("FAIL basic_strobe_cycles got %0d want 20", r_cyc); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL basic_stb_ne_cyc got %0d want 0", r_bad); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16 + i] !== exp_w[i]) begin
                errors++; $display("FAIL basic_word%0d got %h want %h", i, mem[16 + i], exp_w[i]);
            end
        end
        checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL basic_write_count got %0d want 4", wr_log.size()); end
    endtask

    task automatic test_len_zero();
        rd_log.delete(); wr_log.delete();
        run_copy(32'h0, 32'h0, 8'd0, 0, 0);
        checks++; if (r_done !== 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", r_done); end
        checks++; if (r_busy !== 1) begin errors++; $display("FAIL len0_busy_cycles got %0d want 1", r_busy); end
        checks++; if (r_cyc !== 0) begin errors++; $display("FAIL len0_cyc_cycles got %0d want 0", r_cyc); end
        checks++; if (mem[0] !== 32'h11111111) begin errors++; $display("FAIL len0_mem0 got %h want 11111111", mem[0]); end
        checks++; if (rd_log.size() + wr_log.size() !== 0) begin
            errors++; $display("FAIL len0_bus_xfers got %0d want 0", rd_log.size() + wr_log.size()); end
    endtask

    task automatic test_misaligned();
        logic [31:0] ra, wa;
        rd_log.delete(); wr_log.delete();
        run_copy(32'h7, 32'hB, 8'd1, 0, 0);
        ra = (rd_log.size() > 0) ? rd_log[0] : 32'hDEADBEEF;
        wa = (wr_log.size() > 0) ? wr_log[0] : 32'hDEADBEEF;
        checks++; if (ra !== 32'h4) begin errors++; $display("FAIL mis_read_adr got %h want 00000004", ra); end
        checks++; if (wa !== 32'h8) begin errors++; $display("FAIL mis_write_adr got %h want 00000008", wa); end
        checks++; if (mem[2] !== 32'h22222222) begin errors++; $display("FAIL mis_data got %h want 22222222", mem[2]); end
        checks++; if (r_done !== 8) begin errors++; $display("FAIL mis_done_cycle got %0d want 8", r_done); end
    endtask

    task automatic test_timeout();
        rd_log.delete(); wr_log.delete();
        no_ack = 1'b1;
        run_copy(32'h0, 32'h40, 8'd2, 0, 0);
        no_ack = 1'b0;
        checks++; if (r_maxrun !== 8) begin errors++; $display("FAIL tmo_strobe_run got %0d want 8", r_maxrun); end
        checks++; if (r_cyc !== 8) begin errors++; $display("FAIL tmo_strobe_total got %0d want 8", r_cyc); end
        checks++; if (r_done !== 9) begin errors++; $display("FAIL tmo_done_cycle got %0d want 9", r_done); end
        checks++; if (r_err_done !== 1'b1) begin errors++; $display("FAIL tmo_err_at_done got %b want 1", r_err_done); end
        repeat (2) @(negedge wb_clk_i);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b want 1", err_o); end
        for (int i = 32; i < 36; i++) mem[i] = 32'h0;
        run_copy(32'h0, 32'h80, 8'd1, 0, 0);
        checks++; if (r_err1 !== 1'b0) begin errors++; $display("FAIL tmo_err_cleared got %b want 0", r_err1); end
        checks++; if (r_done !== 8) begin errors++; $display("FAIL tmo_recover_done got %0d want 8", r_done); end
        checks++; if (mem[32] !== 32'h11111111) begin errors++; $display("FAIL tmo_recover_data got %h want 11111111", mem[32]); end
    endtask

    task automatic test_reset_mid_copy();
        for (int i = 32; i < 36; i++) mem[i] = 32'h0;
        rd_log.delete(); wr_log.delete();
        run_copy(32'h0, 32'h80, 8'd4, 3, 12);
        checks++; if (r_post_cyc !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc got %b want 0", r_post_cyc); end
        checks++; if (r_post_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", r_post_busy); end
        repeat (10) @(negedge wb_clk_i);
        checks++; if (mem[32] !== 32'h11111111) begin errors++; $display("FAIL rst_mid_word1 got %h want 11111111", mem[32]); end
        checks++; if (mem[34] !== 32'h0 || mem[35] !== 32'h0) begin
            errors++; $display("FAIL rst_mid_tail got %h_%h want 0_0", mem[34], mem[35]); end
        checks++; if (wr_log.size() > 2 || wr_log.size() < 1) begin
            errors++; $display("FAIL rst_mid_writes got %0d want 1..2", wr_log.size()); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b want 0", busy_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] r0, r1;
        mem[63] = 32'hCAFEF00D; mem[48] = 32'h0; mem[49] = 32'h0;
        rd_log.delete(); wr_log.delete();
        run_copy(32'hFFFFFFFC, 32'hC0, 8'd2, 0, 0);
        r0 = (rd_log.size() > 0) ? rd_log[0] : 32'hDEADBEEF;
        r1 = (rd_log.size() > 1) ? rd_log[1] : 32'hDEADBEEF;
        checks++; if (r0 !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_read0 got %h want fffffffc", r0); end
        checks++; if (r1 !== 32'h0) begin errors++; $display("FAIL wrap_read1 got %h want 00000000", r1); end
        checks++; if (mem[48] !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_word0 got %h want cafef00d", mem[48]); end
        checks++; if (mem[49] !== 32'h11111111) begin errors++; $display("FAIL wrap_word1 got %h want 11111111", mem[49]); end
        checks++; if (r_done !== 15) begin errors++; $display("FAIL wrap_done_cycle got %0d want 15", r_done); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_misaligned();
        test_timeout();
        test_reset_mid_copy();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
